// File: rtl/bf16_pkg.sv
// Shared definitions for the bf16 divider: FSM states and format constants.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bf16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int         BF16_BIAS    = 127;
    localparam logic [7:0] BF16_EXP_MAX = 8'hFF;
    localparam int         DIV_STEPS    = 10;

    // Exponent field of zero means zero; denormals are flushed.
    function automatic logic bf16_is_zero(input logic [15:0] v);
        return (v[14:7] == 8'h00);
    endfunction

endpackage

// File: rtl/bf16_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift remainder.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
module bf16_div_step (
    input  logic [9:0] rem,
    input  logic [7:0] divisor,
    output logic       qbit,
    output logic [9:0] rem_next
);

    logic [9:0] kept;

    // Subtract when the divisor fits, then shift the partial remainder left.
    always_comb begin
        qbit     = (rem >= {2'b00, divisor});
        kept     = qbit ? (rem - {2'b00, divisor}) : rem;
        rem_next = kept << 1;
    end

endmodule

// File: rtl/bf16_divider.sv
// Iterative bf16 divider (a/b), one quotient bit per cycle, round on guard&sticky.
// Latency: result valid 11 edges after the accept edge (1 for zero operands).
// Backpressure: single transaction in flight; result held in DONE until out_ready.
module bf16_divider
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_operand,
    input  logic [15:0] b_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        div_by_zero
);

    localparam logic signed [9:0] BIAS10 = 10'(BF16_BIAS);

    state_t      state_q, state_d;
    logic        sign_q, a_zero_q, b_zero_q;
    logic [7:0]  ea_q, eb_q, mb_q;
    logic [9:0]  rem_q, quo_q;
    logic [3:0]  cnt_q;
    logic [15:0] result_q;
    logic        dz_q;

    logic        accept;
    logic        qbit;
    logic [9:0]  rem_next;

    logic [6:0]        mant_pre, mant_fin;
    logic              guard, sticky;
    logic [7:0]        mant_sum;
    logic signed [9:0] e_pre, e_rnd;
    logic [15:0]       norm_res, final_res;
    logic              final_dz;

    assign accept = in_valid && in_ready;

    bf16_div_step u_step (
        .rem      (rem_q),
        .divisor  (mb_q),
        .qbit     (qbit),
        .rem_next (rem_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (bf16_is_zero(a_operand) || bf16_is_zero(b_operand)) state_d = NORM;
                    else                                                     state_d = DIV;
                end
            end
            DIV:  if (cnt_q == 4'(DIV_STEPS - 1)) state_d = NORM;
            NORM: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, division iterations and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            a_zero_q <= 1'b0;
            b_zero_q <= 1'b0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            mb_q     <= 8'd0;
            rem_q    <= 10'd0;
            quo_q    <= 10'd0;
            cnt_q    <= 4'd0;
            result_q <= 16'h0000;
            dz_q     <= 1'b0;
        end else begin
            if (accept) begin
                sign_q   <= a_operand[15] ^ b_operand[15];
                a_zero_q <= bf16_is_zero(a_operand);
                b_zero_q <= bf16_is_zero(b_operand);
                ea_q     <= a_operand[14:7];
                eb_q     <= b_operand[14:7];
                mb_q     <= {1'b1, b_operand[6:0]};
                rem_q    <= {2'b01, a_operand[6:0]};
                quo_q    <= 10'd0;
                cnt_q    <= 4'd0;
            end else if (state_q == DIV) begin
                rem_q <= rem_next;
                quo_q <= {quo_q[8:0], qbit};
                cnt_q <= cnt_q + 4'd1;
            end else if (state_q == NORM) begin
                result_q <= final_res;
                dz_q     <= final_dz;
            end
        end
    end

    // Normalise the quotient, round on guard&sticky, then clamp the exponent.
    always_comb begin
        if (quo_q[9]) begin
            mant_pre = quo_q[8:2];
            guard    = quo_q[1];
            sticky   = quo_q[0] | (rem_q != 10'd0);
            e_pre    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS10;
        end else begin
            mant_pre = quo_q[7:1];
            guard    = quo_q[0];
            sticky   = (rem_q != 10'd0);
            e_pre    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS10 - 10'sd1;
        end
        mant_sum = {1'b0, mant_pre} + {7'd0, guard & sticky};
        if (mant_sum[7]) begin
            mant_fin = 7'd0;
            e_rnd    = e_pre + 10'sd1;
        end else begin
            mant_fin = mant_sum[6:0];
            e_rnd    = e_pre;
        end
        if (e_rnd <= 10'sd0)        norm_res = {sign_q, 15'd0};
        else if (e_rnd >= 10'sd255) norm_res = {sign_q, BF16_EXP_MAX, 7'h00};
        else                        norm_res = {sign_q, e_rnd[7:0], mant_fin};
        final_dz = 1'b0;
        if (b_zero_q) begin
            final_res = {sign_q, BF16_EXP_MAX, 7'h00};
            final_dz  = 1'b1;
        end else if (a_zero_q) begin
            final_res = {sign_q, 15'd0};
        end else begin
            final_res = norm_res;
        end
    end

    assign result      = result_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_bf16_divider.sv
module tb_bf16_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_operand;
    logic [15:0] b_operand;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    bf16_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_operand   (a_operand),
        .b_operand   (b_operand),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Latency counts the accept edge itself as edge 1, up to the edge after
    // which out_valid is first seen high.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic exp_dz,
                          input int exp_lat, input int hold);
        int  lat;
        bit  seen;
        int  guard_cnt;
        logic [15:0] held;
        @(negedge clk);
        a_operand = a;
        b_operand = b;
        in_valid  = 1'b1;
        guard_cnt = 0;
        while (!in_ready && guard_cnt < 20) begin
            @(negedge clk);
            guard_cnt++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check({tag, "_seen_out_valid"}, 32'(seen), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(exp_dz));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            a_operand = 16'h4000;
            b_operand = 16'h3F80;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_result"}, 32'(result), 32'(exp_res));
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_idle"}, 32'(in_ready), 32'd1);
        if (hold > 0) check({tag, "_release_held"}, 32'(result), 32'(held));
    endtask

    initial begin
        bit seen_ov;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_operand = 16'h0000;
        b_operand = 16'h0000;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'h0000);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("one_div_one",   16'h3F80, 16'h3F80, 16'h3F80, 1'b0, 12, 0);
        run_op("one_third",     16'h3F80, 16'h4040, 16'h3EAB, 1'b0, 12, 0);
        run_op("six_div_three", 16'h40C0, 16'h4040, 16'h4000, 1'b0, 12, 0);
        run_op("neg_six",       16'hC0C0, 16'h4040, 16'hC000, 1'b0, 12, 0);
        run_op("two_thirds",    16'h3F80, 16'h3FC0, 16'h3F2B, 1'b0, 12, 0);
        run_op("zero_dividend", 16'h0000, 16'h4000, 16'h0000, 1'b0, 2, 0);
        run_op("denorm_a",      16'h0001, 16'h3F80, 16'h0000, 1'b0, 2, 0);
        run_op("overflow",      16'h7F00, 16'h3F00, 16'h7F80, 1'b0, 12, 0);
        run_op("underflow",     16'h0080, 16'h7F00, 16'h0000, 1'b0, 12, 0);
        run_op("hold_done",     16'h40C0, 16'h4040, 16'h4000, 1'b0, 12, 5);
        run_op("denorm_b",      16'h3F80, 16'h8001, 16'hFF80, 1'b1, 2, 0);
        run_op("div_zero",      16'hBF80, 16'h0000, 16'hFF80, 1'b1, 2, 0);

        // Abort in the middle of DIV: five edges after the accept edge.
        @(negedge clk);
        a_operand = 16'h3F80;
        b_operand = 16'h4040;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'h0000);
        check("abort_dz", 32'(div_by_zero), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_ov = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen_ov = 1'b1;
        end
        check("abort_no_out_valid", 32'(seen_ov), 32'd0);
        run_op("after_abort", 16'h3F80, 16'h4040, 16'h3EAB, 1'b0, 12, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
